// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions for the arbitrated ALU slice: word/control widths,
// operation codes and the supported-operation predicate.
package alu_arbiter_pkg;

  localparam int WORD_LEN    = 32;
  localparam int ALUCTRL_LEN = 4;
  localparam int ALU_REQ_MAX = 8;

  typedef enum logic [ALUCTRL_LEN-1:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_ADDU = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111
  } alu_op_e;

  function automatic logic is_supported(input logic [ALUCTRL_LEN-1:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SLT: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: wrap-around add/sub, bitwise ops, signed set-less-than.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int W = WORD_LEN
) (
  input  logic [W-1:0]           i_a,
  input  logic [W-1:0]           i_b,
  input  logic [ALUCTRL_LEN-1:0] i_ctrl,
  output logic [W-1:0]           o_res
);

  always_comb begin
    // NOTE: default assigned first so every path writes o_res; no latch inferred.
    o_res = '0;
    case (i_ctrl)
      ALU_AND:           o_res = i_a & i_b;
      ALU_OR:            o_res = i_a | i_b;
      ALU_ADD, ALU_ADDU: o_res = i_a + i_b;
      ALU_SUB:           o_res = i_a - i_b;
      ALU_SLT:           o_res = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default:           o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among N_REQ valid/ready requesters;
// one registered response port tagged with the requester index.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W     = WORD_LEN,
  parameter int N_REQ = 2,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_REQ-1:0]             ReqValid,
  output logic [N_REQ-1:0]             ReqReady,
  input  logic [N_REQ*W-1:0]           ReqOp1,
  input  logic [N_REQ*W-1:0]           ReqOp2,
  input  logic [N_REQ*ALUCTRL_LEN-1:0] ReqCtrl,
  output logic                         RespValid,
  input  logic                         RespReady,
  output logic [W-1:0]                 RespRes,
  output logic [IDW-1:0]               RespId,
  output logic                         RespErr
);

  if (N_REQ < 2 || N_REQ > ALU_REQ_MAX) begin : g_bad_n_req
    $error("alu_arbiter: N_REQ out of legal range");
  end

  logic                   r_resp_valid;
  logic [W-1:0]           r_resp_res;
  logic [IDW-1:0]         r_resp_id;
  logic                   r_resp_err;
  logic [IDW-1:0]         r_ptr;

  logic                   w_free;
  logic [N_REQ-1:0]       w_grant;
  logic                   w_accept;
  logic [IDW-1:0]         w_grant_idx;
  logic [IDW-1:0]         w_ptr_next;
  logic [W-1:0]           w_op1;
  logic [W-1:0]           w_op2;
  logic [ALUCTRL_LEN-1:0] w_ctrl;
  logic [W-1:0]           w_alu_res;

  // First valid requester at or above ptr, wrapping; lowest offset wins.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [IDW-1:0]   ptr);
    logic [N_REQ-1:0] g;
    int               idx;
    g = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (valid[idx]) begin
        g      = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  assign w_free   = !r_resp_valid || RespReady;
  assign w_grant  = (rstn && w_free) ? rr_pick(ReqValid, r_ptr) : '0;
  assign w_accept = |w_grant;
  assign ReqReady = w_grant;

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = IDW'(i);
    end
  end

  assign w_ptr_next = (w_grant_idx == IDW'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

  assign w_op1  = ReqOp1[w_grant_idx*W +: W];
  assign w_op2  = ReqOp2[w_grant_idx*W +: W];
  assign w_ctrl = ReqCtrl[w_grant_idx*ALUCTRL_LEN +: ALUCTRL_LEN];

  alu #(.W(W)) u_alu (
    .i_a    (w_op1),
    .i_b    (w_op2),
    .i_ctrl (w_ctrl),
    .o_res  (w_alu_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_res   <= '0;
      r_resp_id    <= '0;
      r_resp_err   <= 1'b0;
      r_ptr        <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking so every register here samples the pre-edge grant state.
      r_resp_valid <= 1'b1;
      r_resp_res   <= is_supported(w_ctrl) ? w_alu_res : '0;
      r_resp_err   <= !is_supported(w_ctrl);
      r_resp_id    <= w_grant_idx;
      r_ptr        <= w_ptr_next;
    end else if (RespReady) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign RespValid = r_resp_valid;
  assign RespRes   = r_resp_res;
  assign RespId    = r_resp_id;
  assign RespErr   = r_resp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a queue-free reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W   = 32;
  localparam int N   = 2;
  localparam int CW  = ALUCTRL_LEN;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   op1;
  logic [N*W-1:0]   op2;
  logic [N*CW-1:0]  ctrl;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_res;
  logic [0:0]       resp_id;
  logic             resp_err;

  int checks   = 0;
  int failures = 0;

  logic         m_valid = 1'b0;
  logic [W-1:0] m_res   = '0;
  int           m_id    = 0;
  logic         m_err   = 1'b0;
  int           m_ptr   = 0;

  alu_arbiter #(.W(W), .N_REQ(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ReqValid  (req_valid),
    .ReqReady  (req_ready),
    .ReqOp1    (op1),
    .ReqOp2    (op2),
    .ReqCtrl   (ctrl),
    .RespValid (resp_valid),
    .RespReady (resp_ready),
    .RespRes   (resp_res),
    .RespId    (resp_id),
    .RespErr   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which requester wins this cycle, or -1.
  function automatic int model_pick();
    if (!rstn) return -1;
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_grant();
    int p;
    p = model_pick();
    return (p < 0) ? '0 : N'(1 << p);
  endfunction

  function automatic logic model_err(input int i);
    logic [CW-1:0] c;
    c = ctrl[i*CW +: CW];
    return !(c == ALU_ADD || c == ALU_ADDU || c == ALU_SUB ||
             c == ALU_AND || c == ALU_OR   || c == ALU_SLT);
  endfunction

  function automatic logic [W-1:0] model_res(input int i);
    logic [W-1:0]  a, b;
    logic [CW-1:0] c;
    a = op1[i*W +: W];
    b = op2[i*W +: W];
    c = ctrl[i*CW +: CW];
    if (c == ALU_ADD || c == ALU_ADDU) return a + b;
    if (c == ALU_SUB)                  return a - b;
    if (c == ALU_AND)                  return a & b;
    if (c == ALU_OR)                   return a | b;
    if (c == ALU_SLT)                  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    return '0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      m_id    <= 0;
      m_err   <= 1'b0;
      m_ptr   <= 0;
    end else if (model_pick() >= 0) begin
      m_valid <= 1'b1;
      m_id    <= model_pick();
      m_res   <= model_res(model_pick());
      m_err   <= model_err(model_pick());
      m_ptr   <= (model_pick() + 1) % N;
    end else if (resp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_ready", req_ready, model_grant());
    check("model_valid", resp_valid, m_valid);
    if (m_valid) begin
      check("model_res", resp_res, m_res);
      check("model_id",  resp_id,  m_id);
      check("model_err", resp_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [CW-1:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl[i*CW +: CW] = c;
    op1[i*W +: W]    = a;
    op2[i*W +: W]    = b;
  endtask

  logic [N-1:0] alt_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [W-1:0] alt_res [4] = '{32'd3, 32'd6, 32'd3, 32'd6};
  logic [CW-1:0] sg_op  [3] = '{ALU_SUB, ALU_SLT, ALU_ADD};
  logic [W-1:0]  sg_a   [3] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic [W-1:0]  sg_b   [3] = '{32'h1, 32'h1, 32'h1};
  logic [W-1:0]  sg_r   [3] = '{32'hFFFFFFFF, 32'h1, 32'h80000000};

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    req_valid  = '0;
    op1        = '0;
    op2        = '0;
    ctrl       = '0;
    resp_ready = 1'b1;
    #12;
    check("rst_valid", resp_valid, 0);
    check("rst_res",   resp_res,   0);
    check("rst_ready", req_ready,  0);
    tick();
    rstn = 1'b1;

    // Single request, no contention
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1 check("single_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("single_valid", resp_valid, 1);
    check("single_res",   resp_res,   32'd12);
    check("single_id",    resp_id,    0);
    check("single_err",   resp_err,   0);

    // Unsupported code from requester 1; pointer moves to 0
    set_req(1, 4'hF, 32'd3, 32'd4);
    req_valid = 2'b10;
    #1 check("unsup_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("unsup_res", resp_res, 0);
    check("unsup_err", resp_err, 1);
    check("unsup_id",  resp_id,  1);

    // Both valid: alternate grants, one result per cycle
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_SUB, 32'd10, 32'd4);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check("alt_ready", req_ready, alt_gnt[k]);
      tick();
      check("alt_valid", resp_valid, 1);
      check("alt_id",    resp_id,    k % 2);
      check("alt_res",   resp_res,   alt_res[k]);
    end

    // Backpressure: hold requester-1 result for three cycles
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", req_ready, 2'b00);
      check("bp_res", resp_res, 32'd6);
      check("bp_id",  resp_id,  1);
      tick();
    end
    resp_ready = 1'b1;
    #1 check("bp_release_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("bp_release_id",  resp_id,  0);
    check("bp_release_res", resp_res, 32'd3);

    // Signed / wrap cases from requester 0
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      set_req(0, sg_op[k], sg_a[k], sg_b[k]);
      tick();
      check("signed_res", resp_res, sg_r[k]);
      check("signed_err", resp_err, 0);
    end
    req_valid = '0;

    // Asynchronous reset while a response is held
    set_req(0, ALU_ADD, 32'd20, 32'd22);
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    tick();
    check("pre_rst_valid", resp_valid, 1);
    req_valid = 2'b11;
    #1 rstn = 1'b0;
    #1;
    check("async_rst_valid", resp_valid, 0);
    check("async_rst_res",   resp_res,   0);
    check("async_rst_id",    resp_id,    0);
    check("async_rst_err",   resp_err,   0);
    check("async_rst_ready", req_ready,  0);
    tick();
    rstn       = 1'b1;
    resp_ready = 1'b1;
    #1 check("post_rst_ready", req_ready, 2'b01);
    tick();
    check("post_rst_id",  resp_id,  0);
    check("post_rst_res", resp_res, 32'd42);
    req_valid = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
